// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates reset, exception, jump, branch, stall and sequential fetch.
// Define PCSEQ_ALIGN_CHECK_EN to trap misaligned redirect targets instead of masking them.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_1000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        resetPC,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        exc_req,
  output logic [31:0] pc_next,
  output logic        flush,
  output logic [31:0] epc,
  output logic [1:0]  state,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2,
    S_EXC  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pendTarget_q, pendTarget_d;

  logic        redirValid;
  logic [31:0] redirTarget;
  logic        doExc;
  logic        doApply;
  logic [31:0] applyTgt;

  // A jump always beats a same-cycle branch; the branch is simply dropped.
  assign redirValid  = jmp_valid | br_valid;
  assign redirTarget = jmp_valid ? jmp_target : br_target;

`ifdef PCSEQ_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    state_d      = state_q;
    flush_d      = 1'b0;
    epc_d        = epc_q;
    pendTarget_d = pendTarget_q;
    pc_next      = pc_cur + 32'd4;
    doExc        = 1'b0;
    doApply      = 1'b0;
    applyTgt     = 32'h0;
`ifdef PCSEQ_ALIGN_CHECK_EN
    misalign_d   = 1'b0;
`endif

    if (resetPC) begin
      pc_next = RESET_VEC;
      state_d = S_RST;
    end else begin
      unique case (state_q)
        S_RST: begin
          pc_next = RESET_VEC;
          state_d = S_RUN;
        end
        S_EXC: begin
          pc_next = pc_cur;
          state_d = S_RUN;
        end
        default: begin
          if (exc_req) begin
            doExc = 1'b1;
          end else if (redirValid && stall) begin
            pendTarget_d = redirTarget;
            pc_next      = pc_cur;
            state_d      = S_PEND;
          end else if (redirValid) begin
            doApply  = 1'b1;
            applyTgt = redirTarget;
          end else if (stall) begin
            pc_next = pc_cur;
          end else if (state_q == S_PEND) begin
            doApply  = 1'b1;
            applyTgt = pendTarget_q;
          end
        end
      endcase

      // Alignment is judged at the moment a target is applied, never at capture.
      if (doApply) begin
`ifdef PCSEQ_ALIGN_CHECK_EN
        if (applyTgt[1:0] != 2'b00) begin
          doExc      = 1'b1;
          misalign_d = 1'b1;
        end else begin
          pc_next      = applyTgt;
          flush_d      = 1'b1;
          pendTarget_d = 32'h0;
          state_d      = S_RUN;
        end
`else
        pc_next      = applyTgt & ~32'h3;
        flush_d      = 1'b1;
        pendTarget_d = 32'h0;
        state_d      = S_RUN;
`endif
      end

      if (doExc) begin
        pc_next      = EXC_VEC;
        epc_d        = pc_cur;
        flush_d      = 1'b1;
        pendTarget_d = 32'h0;
        state_d      = S_EXC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetPC) begin
      state_q      <= S_RST;
      flush_q      <= 1'b0;
      epc_q        <= 32'h0;
      pendTarget_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      epc_q        <= epc_d;
      pendTarget_q <= pendTarget_d;
    end
  end

`ifdef PCSEQ_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (resetPC) misalign_q <= 1'b0;
    else         misalign_q <= misalign_d;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign flush = flush_q;
  assign epc   = epc_q;
  assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver queues expected outputs per cycle and a
// negedge monitor pops and compares them.
module tb_pc_sequencer;

  logic        clk;
  logic        resetPC;
  logic [31:0] pc_cur;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        exc_req;
  logic [31:0] pc_next;
  logic        flush;
  logic [31:0] epc;
  logic [1:0]  state;
  logic        misalign;

`ifdef PCSEQ_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] pcNext;
    logic        flush;
    logic [1:0]  state;
    logic [31:0] epc;
    logic        misalign;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  pc_sequencer dut (
    .clk        (clk),
    .resetPC    (resetPC),
    .pc_cur     (pc_cur),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .exc_req    (exc_req),
    .pc_next    (pc_next),
    .flush      (flush),
    .epc        (epc),
    .state      (state),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField(e.name, "pc_next", pc_next, e.pcNext);
    checkField(e.name, "flush", {31'h0, flush}, {31'h0, e.flush});
    checkField(e.name, "state", {30'h0, state}, {30'h0, e.state});
    checkField(e.name, "epc", epc, e.epc);
    checkField(e.name, "misalign", {31'h0, misalign}, {31'h0, e.misalign});
  endtask

  // Drive one cycle of inputs just after the edge and queue what the outputs must be.
  task automatic applyStimulus(input string name, input logic rst, input logic st,
                               input logic exc, input logic jv, input logic [31:0] jt,
                               input logic bv, input logic [31:0] bt, input logic [31:0] pc,
                               input logic [31:0] eNext, input logic eFlush,
                               input logic [1:0] eState, input logic [31:0] eEpc,
                               input logic eMis);
    exp_t e;
    @(posedge clk);
    #1;
    resetPC    = rst;
    stall      = st;
    exc_req    = exc;
    jmp_valid  = jv;
    jmp_target = jt;
    br_valid   = bv;
    br_target  = bt;
    pc_cur     = pc;
    e.name     = name;
    e.pcNext   = eNext;
    e.flush    = eFlush;
    e.state    = eState;
    e.epc      = eEpc;
    e.misalign = eMis;
    expQ.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic [31:0] epc6;
    int          waitCycles;
    epc6       = ALIGN ? 32'h4004 : 32'h1020;
    resetPC    = 1'b1;
    stall      = 1'b0;
    exc_req    = 1'b0;
    jmp_valid  = 1'b0;
    jmp_target = 32'h0;
    br_valid   = 1'b0;
    br_target  = 32'h0;
    pc_cur     = 32'h0;

    // name          rst st exc jv jt       bv bt       pc_cur    pc_next   fl stt epc       mis
    applyStimulus("rst0",  1, 0, 0, 0, 32'h0,    0, 32'h0,    32'h0,        32'h1000, 0, 0, 32'h0,    0);
    applyStimulus("rst1",  1, 0, 0, 0, 32'h0,    0, 32'h0,    32'h0,        32'h1000, 0, 0, 32'h0,    0);
    applyStimulus("srst",  0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h1000,     32'h1000, 0, 0, 32'h0,    0);
    applyStimulus("seq0",  0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h1000,     32'h1004, 0, 1, 32'h0,    0);
    applyStimulus("seq1",  0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h1004,     32'h1008, 0, 1, 32'h0,    0);
    applyStimulus("wrap",  0, 0, 0, 0, 32'h0,    0, 32'h0,    32'hFFFF_FFFC, 32'h0,   0, 1, 32'h0,    0);
    applyStimulus("stbr",  0, 1, 0, 0, 32'h0,    1, 32'h2000, 32'h1010,     32'h1010, 0, 1, 32'h0,    0);
    applyStimulus("pend1", 0, 1, 0, 0, 32'h0,    0, 32'h0,    32'h1010,     32'h1010, 0, 2, 32'h0,    0);
    applyStimulus("pend2", 0, 1, 0, 0, 32'h0,    0, 32'h0,    32'h1010,     32'h1010, 0, 2, 32'h0,    0);
    applyStimulus("pendgo",0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h1010,     32'h2000, 0, 2, 32'h0,    0);
    applyStimulus("pendfl",0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h2000,     32'h2004, 1, 1, 32'h0,    0);
    applyStimulus("flend", 0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h2004,     32'h2008, 0, 1, 32'h0,    0);
    applyStimulus("jmpbr", 0, 0, 0, 1, 32'h3000, 1, 32'h2000, 32'h2008,     32'h3000, 0, 1, 32'h0,    0);
    applyStimulus("jmpfl", 0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h3000,     32'h3004, 1, 1, 32'h0,    0);
    applyStimulus("jmpend",0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h3004,     32'h3008, 0, 1, 32'h0,    0);
    applyStimulus("stbr2", 0, 1, 0, 0, 32'h0,    1, 32'h2000, 32'h1020,     32'h1020, 0, 1, 32'h0,    0);
    applyStimulus("pexc",  0, 1, 1, 0, 32'h0,    0, 32'h0,    32'h1020,     32'h8000, 0, 2, 32'h0,    0);
    applyStimulus("sexc",  0, 0, 1, 1, 32'h9000, 0, 32'h0,    32'h8000,     32'h8000, 1, 3, 32'h1020, 0);
    applyStimulus("aftexc",0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h8000,     32'h8004, 0, 1, 32'h1020, 0);
    applyStimulus("stbr3", 0, 1, 0, 0, 32'h0,    1, 32'h2000, 32'h8004,     32'h8004, 0, 1, 32'h1020, 0);
    applyStimulus("ovrwr", 0, 1, 0, 1, 32'h4000, 0, 32'h0,    32'h8004,     32'h8004, 0, 2, 32'h1020, 0);
    applyStimulus("ovrgo", 0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h8004,     32'h4000, 0, 2, 32'h1020, 0);
    applyStimulus("ovrfl", 0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h4000,     32'h4004, 1, 1, 32'h1020, 0);
    applyStimulus("misbr", 0, 0, 0, 0, 32'h0,    1, 32'h2002, 32'h4004,
                  ALIGN ? 32'h8000 : 32'h2000, 0, 1, 32'h1020, 0);
    applyStimulus("misnx", 0, 0, 0, 0, 32'h0,    0, 32'h0,    ALIGN ? 32'h8000 : 32'h2000,
                  ALIGN ? 32'h8000 : 32'h2004, 1, ALIGN ? 2'd3 : 2'd1, epc6, ALIGN);
    applyStimulus("misend",0, 0, 0, 0, 32'h0,    0, 32'h0,    ALIGN ? 32'h8000 : 32'h2004,
                  ALIGN ? 32'h8004 : 32'h2008, 0, 1, epc6, 0);
    applyStimulus("stjmp", 0, 1, 0, 1, 32'h5000, 0, 32'h0,    32'h6000,     32'h6000, 0, 1, epc6,     0);
    applyStimulus("rstpd", 1, 1, 0, 0, 32'h0,    0, 32'h0,    32'h6000,     32'h1000, 0, 2, epc6,     0);
    applyStimulus("rstign",0, 0, 1, 0, 32'h0,    1, 32'h7000, 32'h1000,     32'h1000, 0, 0, 32'h0,    0);
    applyStimulus("rstrun",0, 0, 0, 0, 32'h0,    0, 32'h0,    32'h1000,     32'h1004, 0, 1, 32'h0,    0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
